// File: rtl/data_port_arbiter.sv
// data_port_arbiter
//   Shares one RAM data port between two req/gnt/rvalid masters
//   (M0 = core LSU, M1 = debug/loader). Arbitration is round-robin with a
//   grant lock, so a request that has been presented to the RAM is never
//   retargeted before it is granted. Granted transactions are tracked in an
//   ID FIFO so that each RAM rvalid is routed back to the master that issued it.
//
//   Ports
//     clk_i, rstn_i          clock, asynchronous active-low reset
//     mX_req_i .. mX_wdata_i master X request channel (X = 0, 1)
//     mX_gnt_o               master X grant (zero-cycle pass-through of s_gnt_i)
//     mX_rvalid_o/rdata_o    master X response (same cycle as s_rvalid_i)
//     s_*                    RAM-side request/grant/response
//     proto_err_o            sticky: s_rvalid_i arrived with no outstanding ID
module data_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 22,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  output logic                  proto_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_e;

  lock_e                      lock_q, lock_d;
  logic                       last_winner_q, last_winner_d;  // 0 = M0, 1 = M1
  logic [MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       proto_err_q, proto_err_d;

  logic sel;
  logic req_sel;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Selection, RAM request mux, grant and response routing
  always_comb begin
    fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    fifo_empty = (count_q == '0);

    // Unlocked: the lone requester wins; on contention the master that did
    // not win last time wins; with no requester the mux rests on M0.
    unique case (lock_q)
      LOCK_M0: sel = 1'b0;
      LOCK_M1: sel = 1'b1;
      default: sel = (m0_req_i && m1_req_i) ? ~last_winner_q : m1_req_i;
    endcase

    req_sel   = sel ? m1_req_i : m0_req_i;
    // A full FIFO blocks the request even if a pop happens this cycle.
    s_req_o   = req_sel && !fifo_full;
    s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    s_we_o    = sel ? m1_we_i    : m0_we_i;
    s_be_o    = sel ? m1_be_i    : m0_be_i;
    s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    push     = s_req_o && s_gnt_i;
    m0_gnt_o = push && !sel;
    m1_gnt_o = push &&  sel;

    head_id     = id_fifo_q[rd_ptr_q];
    pop         = s_rvalid_i && !fifo_empty;
    m0_rvalid_o = pop && !head_id;
    m1_rvalid_o = pop &&  head_id;
    m0_rdata_o  = s_rdata_i;
    m1_rdata_o  = s_rdata_i;
    proto_err_o = proto_err_q;
  end

  // Next-state: lock, round-robin history, ID FIFO, error flag
  always_comb begin
    lock_d        = lock_q;
    last_winner_d = last_winner_q;
    id_fifo_d     = id_fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    proto_err_d   = proto_err_q;

    if (push) begin
      id_fifo_d[wr_ptr_q] = sel;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
      last_winner_d       = sel;
      lock_d              = LOCK_NONE;
    end else if (s_req_o) begin
      // Presented but not granted: pin the selection until the grant.
      lock_d = sel ? LOCK_M1 : LOCK_M0;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (s_rvalid_i && fifo_empty) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_q        <= LOCK_NONE;
      last_winner_q <= 1'b1;
      id_fifo_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      last_winner_q <= last_winner_d;
      id_fifo_q     <= id_fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// tb_data_port_arbiter
//   Randomized bench for data_port_arbiter. A driver process plays both
//   masters and the RAM, and keeps a transaction-level reference model
//   (outstanding count, pending master, last winner). Expected response
//   owners go into a scoreboard queue; a separate monitor pops it on every
//   RAM response and checks routing of the master rvalids.
module tb_data_port_arbiter;

  localparam int AW   = 22;
  localparam int MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [3:0]    m0_be_i, m1_be_i;
  logic [31:0]   m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0]   m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o, s_gnt_i, s_rvalid_i, proto_err_o;
  logic [AW-1:0] s_addr_o;
  logic [3:0]    s_be_o;
  logic [31:0]   s_wdata_o, s_rdata_i;

  always #5 clk_i = ~clk_i;

  data_port_arbiter #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .proto_err_o(proto_err_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Stimulus knobs (percent probabilities)
  int p_req[2];
  int p_gnt, p_rv;
  bit orphan_pulse = 0;
  bit do_reset     = 0;

  // Master state: a request is held until the master sees its grant
  bit            held[2];
  bit            granted[2];
  logic [AW-1:0] addr_r[2];
  logic          we_r[2];
  logic [3:0]    be_r[2];
  logic [31:0]   wd_r[2];

  // RAM model: read data of granted transactions, returned in order
  logic [31:0] ram_q[$];
  bit          rv_from_ram;

  // Reference model
  int committed;  // master presented to RAM and not yet granted, -1 if none
  int last;       // last master granted
  int n_out;      // transactions granted and awaiting a response
  bit perr;

  // Scoreboard of response owners, pushed one cycle after the grant
  int owner_q[$];
  bit push_pending = 0;
  int push_id;

  task automatic model_reset();
    committed    = -1;
    last         = 1;
    n_out        = 0;
    perr         = 0;
    owner_q.delete();
    push_pending = 0;
  endtask

  task automatic set_knobs(input int r0, input int r1, input int g, input int rv);
    p_req[0] = r0; p_req[1] = r1; p_gnt = g; p_rv = rv;
  endtask

  task automatic one_cycle();
    int  cand;
    bit  full, present, exp_gnt;
    @(posedge clk_i);
    #1;
    if (push_pending) begin
      owner_q.push_back(push_id);
      push_pending = 0;
    end
    for (int x = 0; x < 2; x++) begin
      if (granted[x]) held[x] = 0;
      granted[x] = 0;
      if (!held[x]) begin
        held[x]   = ($urandom_range(99) < p_req[x]);
        addr_r[x] = AW'($urandom);
        we_r[x]   = 1'($urandom);
        be_r[x]   = 4'($urandom);
        wd_r[x]   = $urandom;
      end
    end
    m0_req_i = held[0]; m0_addr_i = addr_r[0]; m0_we_i = we_r[0]; m0_be_i = be_r[0]; m0_wdata_i = wd_r[0];
    m1_req_i = held[1]; m1_addr_i = addr_r[1]; m1_we_i = we_r[1]; m1_be_i = be_r[1]; m1_wdata_i = wd_r[1];
    rstn_i      = !do_reset;
    s_gnt_i     = !do_reset && ($urandom_range(99) < p_gnt);
    rv_from_ram = 0;
    if (!do_reset && ram_q.size() > 0 && $urandom_range(99) < p_rv) begin
      s_rvalid_i  = 1'b1;
      s_rdata_i   = ram_q[0];
      rv_from_ram = 1;
    end else if (!do_reset && orphan_pulse) begin
      s_rvalid_i   = 1'b1;
      s_rdata_i    = $urandom;
      orphan_pulse = 0;
    end else begin
      s_rvalid_i = 1'b0;
      s_rdata_i  = $urandom;
    end

    @(negedge clk_i);
    if (do_reset) begin
      model_reset();
      do_reset = 0;
      return;
    end

    full = (n_out == MAXO);
    if (committed >= 0)          cand = committed;
    else if (held[0] && held[1]) cand = 1 - last;
    else if (held[1])            cand = 1;
    else                         cand = 0;
    present = held[cand] && !full;
    exp_gnt = present && s_gnt_i;

    check("s_req_o", 128'(s_req_o), 128'(present));
    check("grants", 128'({m1_gnt_o, m0_gnt_o}),
          128'(exp_gnt ? ((cand == 1) ? 2'b10 : 2'b01) : 2'b00));
    check("s_addr_o", 128'(s_addr_o), 128'(addr_r[cand]));
    check("s_we_be_wdata", 128'({s_we_o, s_be_o, s_wdata_o}),
          128'({we_r[cand], be_r[cand], wd_r[cand]}));
    check("proto_err_o", 128'(proto_err_o), 128'(perr));

    if (s_rvalid_i) begin
      if (n_out > 0) n_out--;
      else           perr = 1;
    end
    if (exp_gnt) begin
      n_out++;
      last         = cand;
      committed    = -1;
      push_pending = 1;
      push_id      = cand;
    end else if (present) begin
      committed = cand;
    end

    granted[0] = m0_gnt_o;
    granted[1] = m1_gnt_o;
    if (rv_from_ram) void'(ram_q.pop_front());
    if (s_req_o && s_gnt_i) ram_q.push_back($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  // Response monitor
  always @(negedge clk_i) begin
    int owner;
    if (rstn_i === 1'b1) begin
      if (s_rvalid_i) begin
        if (owner_q.size() > 0) begin
          owner = owner_q.pop_front();
          check("rvalid_route", 128'({m1_rvalid_o, m0_rvalid_o}),
                128'((owner == 1) ? 2'b10 : 2'b01));
          check("rdata", 128'({m1_rdata_o, m0_rdata_o}), 128'({s_rdata_i, s_rdata_i}));
        end else begin
          check("orphan_rvalid", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(2'b00));
        end
      end else begin
        check("idle_rvalid", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(2'b00));
      end
    end
  end

  initial begin
    rstn_i = 1'b0;
    m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
    for (int x = 0; x < 2; x++) begin
      held[x] = 0; granted[x] = 0; addr_r[x] = '0; we_r[x] = 0; be_r[x] = '0; wd_r[x] = '0;
    end
    model_reset();
    #2;
    check("reset_s_req", 128'(s_req_o), 128'(0));
    check("reset_gnt", 128'({m1_gnt_o, m0_gnt_o}), 128'(0));
    check("reset_rvalid", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(0));
    check("reset_proto_err", 128'(proto_err_o), 128'(0));

    // M0 alone, immediate grant and response
    set_knobs(100, 0, 100, 100); run(6);
    set_knobs(0, 0, 100, 100);   run(4);
    // Both masters continuously: alternating grants
    set_knobs(100, 100, 100, 100); run(10);
    set_knobs(0, 0, 100, 100);     run(4);
    // Lock: M1 presented without grant, M0 joins, lock must hold
    set_knobs(0, 100, 0, 0);     run(1);
    set_knobs(100, 100, 0, 0);   run(2);
    set_knobs(100, 100, 100, 0); run(2);
    set_knobs(0, 0, 100, 100);   run(6);
    // FIFO full: responses withheld, then released
    set_knobs(100, 100, 100, 0);   run(5);
    set_knobs(100, 100, 100, 100); run(5);
    set_knobs(0, 0, 100, 100);     run(6);
    // Orphan response sets sticky error
    set_knobs(0, 0, 0, 0); orphan_pulse = 1; run(4);
    // Reset with work outstanding and M1 locked
    set_knobs(100, 0, 100, 0); run(1);
    set_knobs(0, 100, 0, 0);   run(2);
    do_reset = 1; run(1);
    set_knobs(0, 0, 0, 100);       run(6);
    set_knobs(100, 100, 100, 100); run(6);
    set_knobs(0, 0, 100, 100);     run(6);

    // Randomized phase with occasional mid-traffic resets
    for (int seg = 0; seg < 60; seg++) begin
      set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100), $urandom_range(100));
      if ($urandom_range(9) == 0) do_reset = 1;
      run(50);
    end
    set_knobs(0, 0, 100, 100); run(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
